// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse character player.
package morse_pkg;

    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned GAP_UNITS  = 1;
    localparam int unsigned MAX_LEN    = 5;
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/unit_counter.sv
// Counts unit_tick pulses up to a runtime target; hit_c flags the target-th tick.
module unit_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic             hit_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);
    assign hit_c   = tick && (cnt_inc == target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/morse_symbol_player.sv
// Plays one latched Morse character on led_out, timing marks and gaps in unit_tick pulses.
module morse_symbol_player #(
    parameter int unsigned DOT_UNITS  = morse_pkg::DOT_UNITS,
    parameter int unsigned DASH_UNITS = morse_pkg::DASH_UNITS,
    parameter int unsigned GAP_UNITS  = morse_pkg::GAP_UNITS,
    parameter int unsigned MAX_LEN    = morse_pkg::MAX_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               unit_tick,
    input  logic               start,
    input  logic [2:0]         code_len,
    input  logic [MAX_LEN-1:0] code_bits,
    output logic               busy,
    output logic               led_out,
    output logic               done
);

    import morse_pkg::*;

    localparam int unsigned CNT_W  = $clog2(DASH_UNITS + 1);
    localparam int unsigned CLEN_W = $clog2(MAX_LEN + 1);

    state_t              state;
    logic [MAX_LEN-1:0]  pat;
    logic [CLEN_W-1:0]   len;
    logic [CLEN_W-1:0]   idx;

    logic                cnt_tick_c;
    logic                load_c;
    logic                hit_c;
    logic                last_c;
    logic [CNT_W-1:0]    target_c;
    logic [CLEN_W-1:0]   len_in_c;

    assign len_in_c   = (code_len > 3'(MAX_LEN)) ? CLEN_W'(MAX_LEN) : CLEN_W'(code_len);
    assign cnt_tick_c = unit_tick && ((state == MARK) || (state == SPACE));
    // Counter restarts on every phase change and stays cleared outside MARK/SPACE.
    assign load_c     = (state == IDLE) || (state == DONE) || hit_c;
    assign target_c   = (state == SPACE) ? CNT_W'(GAP_UNITS)
                      : (pat[0] ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS));
    assign last_c     = (idx == (len - CLEN_W'(1)));

    unit_counter #(
        .CNT_W (CNT_W)
    ) u_unit_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .tick   (cnt_tick_c),
        .target (target_c),
        .hit_c  (hit_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pat     <= '0;
            len     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            led_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat <= code_bits;
                        len <= len_in_c;
                        idx <= '0;
                        if (len_in_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= MARK;
                            busy    <= 1'b1;
                            led_out <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (hit_c) begin
                        idx     <= idx + CLEN_W'(1);
                        pat     <= pat >> 1;
                        led_out <= 1'b0;
                        if (last_c) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= SPACE;
                        end
                    end
                end
                SPACE: begin
                    if (hit_c) begin
                        state   <= MARK;
                        led_out <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_symbol_player.sv
// Scoreboard bench: expected mark/space/done segments are queued at start and matched by a monitor.
module tb_morse_symbol_player;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       unit_tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] code_len = 3'd0;
    logic [4:0] code_bits = 5'd0;
    logic       busy;
    logic       led_out;
    logic       done;

    morse_symbol_player dut (
        .clk       (clk),
        .rst       (rst),
        .unit_tick (unit_tick),
        .start     (start),
        .code_len  (code_len),
        .code_bits (code_bits),
        .busy      (busy),
        .led_out   (led_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 1 = mark, 2 = space, 3 = done
        int ticks;
    } seg_t;

    seg_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tick_per = 4;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic pop_exp(output seg_t e);
        if (exp_q.size() == 0) begin
            e.kind  = -1;
            e.ticks = -1;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic push_char(input logic [2:0] len, input logic [4:0] bits);
        int   l;
        seg_t s;
        l = (len > 3'd5) ? 5 : int'(len);
        for (int i = 0; i < l; i++) begin
            s.kind  = 1;
            s.ticks = bits[i] ? 3 : 1;
            exp_q.push_back(s);
            if (i < l - 1) begin
                s.kind  = 2;
                s.ticks = 1;
                exp_q.push_back(s);
            end
        end
        s.kind  = 3;
        s.ticks = 0;
        exp_q.push_back(s);
    endtask

    // Free-running tick source, one pulse every tick_per cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            unit_tick = ((cyc % tick_per) == 0);
        end
    end

    int   cur_kind = 0;
    int   cur_ticks = 0;
    logic last_tick = 1'b0;
    int   mon_k;
    seg_t mon_e;

    // Segment monitor: closes a segment whenever the (busy, led, done) class changes.
    always @(negedge clk) begin
        if (!rst) begin
            cur_kind  = 0;
            cur_ticks = 0;
        end else begin
            mon_k = done ? 3 : (busy ? (led_out ? 1 : 2) : 0);
            if (mon_k != cur_kind || mon_k == 3) begin
                if (cur_kind == 1 || cur_kind == 2) begin
                    pop_exp(mon_e);
                    check("seg_kind", cur_kind, mon_e.kind);
                    check("seg_ticks", cur_ticks, mon_e.ticks);
                    check("seg_end_on_tick", last_tick, 1);
                end
                if (mon_k == 3) begin
                    pop_exp(mon_e);
                    check("done_slot", mon_k, mon_e.kind);
                    check("done_led", led_out, 0);
                    check("done_busy", busy, 0);
                end
                cur_kind  = mon_k;
                cur_ticks = 0;
            end
            if (mon_k == 1 || mon_k == 2) begin
                cur_ticks = cur_ticks + int'(unit_tick);
                last_tick = unit_tick;
            end
            if (mon_k == 0) check("idle_led", led_out, 0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("done_timeout", 0, 1);
    endtask

    task automatic play(input logic [2:0] len, input logic [4:0] bits, input bit disturb);
        wait_idle();
        @(posedge clk);
        #2;
        start     = 1'b1;
        code_len  = len;
        code_bits = bits;
        push_char(len, bits);
        @(posedge clk);
        #2;
        start     = 1'b0;
        code_bits = ~bits;
        code_len  = 3'd1;
        @(negedge clk);
        if (len == 3'd0) begin
            check("len0_done", done, 1);
            check("len0_led", led_out, 0);
        end else begin
            check("start_busy", busy, 1);
            check("start_led", led_out, 1);
            if (disturb) begin
                repeat (6) @(negedge clk);
                @(posedge clk);
                #2;
                start     = 1'b1;
                code_bits = 5'b10101;
                code_len  = 3'd2;
                check("disturb_busy", busy, 1);
                @(posedge clk);
                #2;
                start = 1'b0;
                @(negedge clk);
            end
            wait_done();
        end
    endtask

    task automatic held_e();
        wait_idle();
        @(posedge clk);
        #2;
        start     = 1'b1;
        code_len  = 3'd1;
        code_bits = 5'b00000;
        push_char(3'd1, 5'b00000);
        push_char(3'd1, 5'b00000);
        @(negedge clk);
        wait_done();
        @(negedge clk);
        check("held_gap_busy", busy, 0);
        @(posedge clk);
        #2;
        start = 1'b0;
        @(negedge clk);
        check("held_restart_busy", busy, 1);
        wait_done();
    endtask

    task automatic abort_a();
        int   rises = 0;
        int   n = 0;
        logic prev = 1'b0;
        wait_idle();
        @(posedge clk);
        #2;
        start     = 1'b1;
        code_len  = 3'd2;
        code_bits = 5'b00010;
        push_char(3'd2, 5'b00010);
        @(posedge clk);
        #2;
        start = 1'b0;
        while (rises < 2 && n < 1000) begin
            @(negedge clk);
            if (led_out && !prev) rises++;
            prev = led_out;
            n++;
        end
        if (n >= 1000) check("dash_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_led", led_out, 1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_led", led_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_done", done, 0);
        end
        #1;
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_led", led_out, 0);
        check("reset_done", done, 0);
        rst = 1'b1;

        tick_per = 4;
        while (cyc < 9) @(posedge clk);
        play(3'd1, 5'b00000, 1'b0);   // E
        play(3'd2, 5'b00010, 1'b0);   // A

        tick_per = 2;
        play(3'd5, 5'b11111, 1'b1);   // 0, with mid-character disturbance
        play(3'd0, 5'b11111, 1'b0);
        play(3'd7, 5'b11111, 1'b0);   // clamped to 5

        tick_per = 1;
        play(3'd2, 5'b00001, 1'b0);   // N
        play(3'd3, 5'b00101, 1'b0);   // K

        tick_per = 3;
        held_e();
        abort_a();
        play(3'd1, 5'b00000, 1'b0);   // E after reset

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_symbol_player.md
Name: morse_symbol_player

Overview:
Downstream consumer of the timer chain's timeout pulse. It takes one Morse character (pattern plus length), loaded from the character ROM by the game controller, and plays it on the LED output. Mark and space durations are measured in unit_tick pulses, not clock cycles. It raises busy while playing and gives a 1-cycle done pulse when the last mark ends.

Parameters:
DOT_UNITS, 1, unit_tick pulses per dot mark
DASH_UNITS, 3, unit_tick pulses per dash mark
GAP_UNITS, 1, unit_tick pulses of LED-off between symbols of one character
MAX_LEN, 5, max symbols per character; also the code_bits width

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
unit_tick  input  1  1-cycle timing pulse from the timeout counter chain
start  input  1  request to play; sampled only in IDLE
code_len  input  3  symbols in the character, 0..7; values above MAX_LEN are clamped to MAX_LEN
code_bits  input  MAX_LEN  symbol pattern, LSB first; 0 = dot, 1 = dash
busy  output  1  high from the cycle after start is accepted until done
led_out  output  1  Morse output; 1 = mark
done  output  1  1-cycle pulse at end of character

Behaviour:
- Reset (rst = 0, async): state IDLE; busy = 0, led_out = 0, done = 0; all counters and latched pattern cleared. Reset mid-character aborts immediately, with no done pulse.
- All outputs are registered.
- IDLE:
  - start = 1 latches code_bits, the clamped length, and symbol index 0.
  - If length = 0, the next cycle goes to DONE (done = 1 for one cycle, led stays 0).
  - Otherwise the next cycle goes to MARK with led_out = 1 and busy = 1.
- MARK:
  - target = DASH_UNITS if the current bit is 1, else DOT_UNITS.
  - unit_tick pulses are counted, including a tick in the entry cycle.
  - On the target-th tick: if the index is the last symbol, go to DONE; otherwise go to SPACE. The index increments on leaving MARK.
- SPACE: led_out = 0. On the GAP_UNITS-th tick, go to MARK.
- DONE: done = 1, busy = 0 and led_out = 0 in this same cycle; return to IDLE next cycle. There is no trailing gap after the last symbol.
- Tick counter: resets to 0 on every state entry. Width is clog2(DASH_UNITS+1); it never wraps within a phase.
- start while busy or in DONE: ignored, with no queueing.
- start and unit_tick in the same IDLE cycle: the tick is not counted.
- start held high continuously: a new character is accepted in the first IDLE cycle after DONE.
- code_bits and code_len changing while busy: no effect, because both are latched.
- Timing: each mark/space lasts exactly N ticks, so wall time is N × tick period, ±1 tick period for the first phase depending on start alignment.

Decomposition:
- Package morse_pkg holds:
  - state encoding: IDLE, MARK, SPACE, DONE
  - default constants DOT_UNITS, DASH_UNITS, GAP_UNITS, MAX_LEN
  - width of the clamped length field
- Sub-module unit_counter: counts unit_tick up to a runtime target, with clear-on-load and a one-cycle hit output. It is instantiated once; the FSM and shift/index logic stay in the top.

Test Plan:
- 'E' (len 1, bits 00000), tick every 4 cycles, start at cycle 10:
  - busy/led rise at cycle 11.
  - led falls together with the done pulse one cycle after the first tick.
  - Exactly 1 tick of mark.
- 'A' (len 2, bits 00010), tick every 4 cycles:
  - led pattern in ticks: on 1, off 1, on 3.
  - done once; busy covers the whole sequence.
- '0' (len 5, bits 11111):
  - five 3-tick marks separated by 1-tick gaps.
  - busy high for 19 ticks of phases; exactly one done pulse.
- Boundary cases:
  - code_len = 0 → done pulses the cycle after start, led never rises.
  - code_len = 7 with bits 11111 → plays as len 5.
- start asserted mid-character, and code_bits changed mid-character → output sequence unchanged.
- rst pulled low during the dash of 'A' → led, busy and done go 0 asynchronously with no done pulse. After release, a new start plays 'E' correctly.
